// File: rtl/qeciphy_error_collector.sv
// Multi-source error collector: first-fatal latch, per-source sticky flags and
// saturating counters, plus a small event-log FIFO for the controller.
module qeciphy_error_collector #(
  parameter int NUM_SRC                     = 8,
  parameter int CODE_W                      = 4,
  parameter int CNT_W                       = 8,
  parameter int LOG_DEPTH                   = 4,
  parameter logic [NUM_SRC-1:0] FATAL_MASK  = 8'h07,
  localparam int SRC_W                      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_SRC-1:0]          err_valid_i,
  input  logic [NUM_SRC*CODE_W-1:0]   err_code_i,
  input  logic                        clear_i,
  output logic                        fault_fatal_o,
  output logic [CODE_W-1:0]           ecode_o,
  output logic [SRC_W-1:0]            first_src_o,
  output logic                        warn_o,
  output logic [NUM_SRC-1:0]          sticky_o,
  output logic [NUM_SRC*CNT_W-1:0]    count_o,
  output logic                        log_valid_o,
  input  logic                        log_ready_i,
  output logic [SRC_W-1:0]            log_src_o,
  output logic [CODE_W-1:0]           log_code_o,
  output logic                        log_lost_o
);

  localparam int AW    = $clog2(LOG_DEPTH);
  localparam int PTR_W = AW + 1;

  logic [NUM_SRC-1:0] evt_q;
  logic [NUM_SRC-1:0] ev;
  logic [NUM_SRC-1:0] fev;
  logic [NUM_SRC-1:0] sticky_q;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];

  logic               fatal_q;
  logic [CODE_W-1:0]  ecode_q;
  logic [SRC_W-1:0]   first_src_q;
  logic               lost_q;

  logic [SRC_W-1:0]   ev_idx;
  logic [SRC_W-1:0]   fev_idx;
  logic [CODE_W-1:0]  ev_code;
  logic [CODE_W-1:0]  fev_code;
  logic               ev_any;
  logic               multi_ev;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [SRC_W-1:0]   mem_src  [LOG_DEPTH];
  logic [CODE_W-1:0]  mem_code [LOG_DEPTH];
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               lost_now;

  // Priority encoder: index 0 wins, so scan downwards and let lower bits overwrite.
  function automatic logic [SRC_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SRC_W'(i);
    end
  endfunction

  always_comb begin
    ev       = err_valid_i & ~evt_q;
    fev      = ev & FATAL_MASK;
    ev_any   = |ev;
    multi_ev = |(ev & (ev - NUM_SRC'(1)));
    ev_idx   = lowest_idx(ev);
    fev_idx  = lowest_idx(fev);
    ev_code  = err_code_i[ev_idx*CODE_W +: CODE_W];
    fev_code = err_code_i[fev_idx*CODE_W +: CODE_W];
  end

  // Full when the pointers differ only in the wrap bit.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = ~fifo_empty & log_ready_i;
    push       = ev_any & (~fifo_full | pop);
    lost_now   = multi_ev | (ev_any & fifo_full & ~pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_q    <= '0;
      sticky_q <= '0;
      lost_q   <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      evt_q    <= err_valid_i;
      sticky_q <= ev | (sticky_q & ~{NUM_SRC{clear_i}});
      lost_q   <= lost_now | (lost_q & ~clear_i);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (clear_i) begin
          cnt_q[i] <= CNT_W'(ev[i]);
        end else if (ev[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // The first fatal event freezes source and code until the next reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fatal_q     <= 1'b0;
      ecode_q     <= '0;
      first_src_q <= '0;
    end else if (!fatal_q && (|fev)) begin
      fatal_q     <= 1'b1;
      ecode_q     <= fev_code;
      first_src_q <= fev_idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < LOG_DEPTH; i++) begin
        mem_src[i]  <= '0;
        mem_code[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_src[wr_ptr[AW-1:0]]  <= ev_idx;
        mem_code[wr_ptr[AW-1:0]] <= ev_code;
        wr_ptr                   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      count_o[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign fault_fatal_o = fatal_q;
  assign ecode_o       = ecode_q;
  assign first_src_o   = first_src_q;
  assign sticky_o      = sticky_q;
  assign warn_o        = |(sticky_q & ~FATAL_MASK);
  assign log_valid_o   = ~fifo_empty;
  assign log_src_o     = mem_src[rd_ptr[AW-1:0]];
  assign log_code_o    = mem_code[rd_ptr[AW-1:0]];
  assign log_lost_o    = lost_q;

endmodule

// File: tb/tb_qeciphy_error_collector.sv
// Directed self-checking bench for qeciphy_error_collector with default parameters.
module tb_qeciphy_error_collector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  err_valid_i;
  logic [31:0] err_code_i;
  logic        clear_i;
  logic        fault_fatal_o;
  logic [3:0]  ecode_o;
  logic [2:0]  first_src_o;
  logic        warn_o;
  logic [7:0]  sticky_o;
  logic [63:0] count_o;
  logic        log_valid_o;
  logic        log_ready_i;
  logic [2:0]  log_src_o;
  logic [3:0]  log_code_o;
  logic        log_lost_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  qeciphy_error_collector dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .err_valid_i  (err_valid_i),
    .err_code_i   (err_code_i),
    .clear_i      (clear_i),
    .fault_fatal_o(fault_fatal_o),
    .ecode_o      (ecode_o),
    .first_src_o  (first_src_o),
    .warn_o       (warn_o),
    .sticky_o     (sticky_o),
    .count_o      (count_o),
    .log_valid_o  (log_valid_o),
    .log_ready_i  (log_ready_i),
    .log_src_o    (log_src_o),
    .log_code_o   (log_code_o),
    .log_lost_o   (log_lost_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int src, input logic [3:0] code, input logic valid);
    err_code_i[src*4 +: 4] = code;
    err_valid_i[src]       = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt(input int i);
    return count_o[i*8 +: 8];
  endfunction

  int          t5_src  [6] = '{3, 4, 5, 6, 7, 3};
  logic [3:0]  t5_code [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  int          exp_src [4] = '{4, 5, 6, 5};
  logic [3:0]  exp_code[4] = '{4'h2, 4'h3, 4'h4, 4'hA};

  initial begin
    rst_i       = 1'b1;
    err_valid_i = '0;
    err_code_i  = '0;
    clear_i     = 1'b0;
    log_ready_i = 1'b0;
    tick();
    tick();
    checkOutput("rst_fatal",  fault_fatal_o, 0);
    checkOutput("rst_sticky", sticky_o, 0);
    checkOutput("rst_count",  count_o, 0);
    checkOutput("rst_logv",   log_valid_o, 0);
    checkOutput("rst_warn",   warn_o, 0);
    rst_i = 1'b0;
    tick();

    $display("[TB] step 1: warning source 5");
    applyStimulus(5, 4'h9, 1'b1);
    tick();
    checkOutput("s1_sticky", sticky_o, 8'h20);
    checkOutput("s1_warn",   warn_o, 1);
    checkOutput("s1_cnt5",   cnt(5), 1);
    checkOutput("s1_fatal",  fault_fatal_o, 0);
    checkOutput("s1_logv",   log_valid_o, 1);
    checkOutput("s1_lsrc",   log_src_o, 5);
    checkOutput("s1_lcode",  log_code_o, 4'h9);
    applyStimulus(5, 4'h9, 1'b0);
    log_ready_i = 1'b1;
    tick();
    checkOutput("s1_popped", log_valid_o, 0);
    checkOutput("s1_cnt5_hold", cnt(5), 1);
    log_ready_i = 1'b0;

    $display("[TB] step 2: simultaneous fatal sources 1 and 2");
    applyStimulus(1, 4'h3, 1'b1);
    applyStimulus(2, 4'h7, 1'b1);
    tick();
    checkOutput("s2_fatal",  fault_fatal_o, 1);
    checkOutput("s2_first",  first_src_o, 1);
    checkOutput("s2_ecode",  ecode_o, 4'h3);
    checkOutput("s2_lsrc",   log_src_o, 1);
    checkOutput("s2_lcode",  log_code_o, 4'h3);
    checkOutput("s2_lost",   log_lost_o, 1);
    checkOutput("s2_sticky", sticky_o, 8'h26);
    checkOutput("s2_cnt2",   cnt(2), 1);
    applyStimulus(1, 4'h3, 1'b0);
    applyStimulus(2, 4'h7, 1'b0);
    tick();

    $display("[TB] step 3: later fatal, then clear");
    applyStimulus(0, 4'h5, 1'b1);
    tick();
    checkOutput("s3_ecode",  ecode_o, 4'h3);
    checkOutput("s3_first",  first_src_o, 1);
    checkOutput("s3_sticky", sticky_o, 8'h27);
    applyStimulus(0, 4'h5, 1'b0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("s3_clr_sticky", sticky_o, 0);
    checkOutput("s3_clr_count",  count_o, 0);
    checkOutput("s3_clr_lost",   log_lost_o, 0);
    checkOutput("s3_clr_warn",   warn_o, 0);
    checkOutput("s3_clr_fatal",  fault_fatal_o, 1);
    checkOutput("s3_clr_ecode",  ecode_o, 4'h3);
    checkOutput("s3_head0_src",  log_src_o, 1);
    checkOutput("s3_head0_code", log_code_o, 4'h3);
    log_ready_i = 1'b1;
    tick();
    checkOutput("s3_head1_src",  log_src_o, 0);
    checkOutput("s3_head1_code", log_code_o, 4'h5);
    tick();
    checkOutput("s3_empty", log_valid_o, 0);
    log_ready_i = 1'b0;

    $display("[TB] step 4: counter saturation");
    for (int k = 0; k < 300; k++) begin
      applyStimulus(3, 4'h2, 1'b1);
      tick();
      applyStimulus(3, 4'h2, 1'b0);
      tick();
    end
    checkOutput("s4_sat",    cnt(3), 8'd255);
    checkOutput("s4_warn",   warn_o, 1);
    checkOutput("s4_lost",   log_lost_o, 1);
    applyStimulus(3, 4'h2, 1'b1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("s4_clr_ev_cnt",    cnt(3), 1);
    checkOutput("s4_clr_ev_sticky", sticky_o, 8'h08);
    checkOutput("s4_clr_ev_lost",   log_lost_o, 1);
    applyStimulus(3, 4'h2, 1'b0);
    log_ready_i = 1'b1;
    repeat (4) tick();
    checkOutput("s4_flushed", log_valid_o, 0);
    log_ready_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("s4_lost_clr", log_lost_o, 0);

    $display("[TB] step 5: log overflow and pop+push while full");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(t5_src[k], t5_code[k], 1'b1);
      tick();
      applyStimulus(t5_src[k], t5_code[k], 1'b0);
      tick();
    end
    checkOutput("s5_lost",   log_lost_o, 1);
    checkOutput("s5_sticky", sticky_o, 8'hF8);
    checkOutput("s5_cnt3",   cnt(3), 2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("s5_lost_clr", log_lost_o, 0);
    checkOutput("s5_cnt3_clr", cnt(3), 0);
    checkOutput("s5_head_src",  log_src_o, 3);
    checkOutput("s5_head_code", log_code_o, 4'h1);
    log_ready_i = 1'b1;
    applyStimulus(5, 4'hA, 1'b1);
    tick();
    checkOutput("s5_pp_lost",  log_lost_o, 0);
    checkOutput("s5_pp_valid", log_valid_o, 1);
    applyStimulus(5, 4'hA, 1'b0);
    log_ready_i = 1'b0;
    tick();
    log_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s5_pop%0d_src", k),  log_src_o, exp_src[k]);
      checkOutput($sformatf("s5_pop%0d_code", k), log_code_o, exp_code[k]);
      tick();
    end
    checkOutput("s5_drained", log_valid_o, 0);
    log_ready_i = 1'b0;

    $display("[TB] step 6: async reset with source 4 held high");
    applyStimulus(4, 4'hC, 1'b1);
    tick();
    checkOutput("s6_pre_cnt4", cnt(4), 1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("s6_rst_fatal",  fault_fatal_o, 0);
    checkOutput("s6_rst_ecode",  ecode_o, 0);
    checkOutput("s6_rst_first",  first_src_o, 0);
    checkOutput("s6_rst_sticky", sticky_o, 0);
    checkOutput("s6_rst_count",  count_o, 0);
    checkOutput("s6_rst_logv",   log_valid_o, 0);
    checkOutput("s6_rst_warn",   warn_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    checkOutput("s6_rel_cnt4",   cnt(4), 1);
    checkOutput("s6_rel_sticky", sticky_o, 8'h10);
    checkOutput("s6_rel_lsrc",   log_src_o, 4);
    checkOutput("s6_rel_lcode",  log_code_o, 4'hC);
    tick();
    checkOutput("s6_hold_cnt4",  cnt(4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
